// File: rtl/sbqm_pkg.sv
// sbqm_pkg: shared FSM state type and default sizing constants for the queue controller.
package sbqm_pkg;
  typedef enum logic [0:0] {IDLE, CALC} qc_state_t;
  localparam int SBQM_DEPTH = 7;
  localparam int SBQM_TELLERS_MAX = 3;
  localparam int SBQM_SERVICE_T = 3;
endpackage

// File: rtl/sbqm_div.sv
// sbqm_div: sequential unsigned restoring divider, one quotient bit per cycle, W iterations.
// The start edge performs the first iteration; done and quot present the final iteration combinationally.
module sbqm_div
  import sbqm_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quot
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0]  r, q, r_in, q_in, r_nx, q_nx;
  logic [W:0]    rs, diff;
  logic [CW-1:0] cnt;
  always_comb begin
    r_in = start ? '0 : r;
    q_in = start ? num : q;
    rs   = {r_in, q_in[W-1]};
    diff = rs - {1'b0, den};
    r_nx = diff[W] ? rs[W-1:0] : diff[W-1:0];
    q_nx = {q_in[W-2:0], ~diff[W]};
  end
  // start takes priority so an in-flight division can be restarted with new operands
  assign done = !start && busy && cnt == CW'(W - 1);
  assign quot = q_nx;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r    <= '0;
      q    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start || busy) begin
      r    <= r_nx;
      q    <= q_nx;
      cnt  <= start ? CW'(1) : cnt + CW'(1);
      busy <= start || !done;
    end
  end
endmodule

// File: rtl/sbqm_queue_ctrl.sv
// sbqm_queue_ctrl: queue occupancy counter with full/empty flags and a wait-time estimator.
// Optional sticky overflow/underflow flags are enabled with SBQM_ERR_FLAGS_EN.
module sbqm_queue_ctrl
  import sbqm_pkg::*;
#(
  parameter int DEPTH = SBQM_DEPTH,
  parameter int TELLERS_MAX = SBQM_TELLERS_MAX,
  parameter int SERVICE_T = SBQM_SERVICE_T,
  localparam int PC_W = $clog2(DEPTH + 1),
  localparam int TC_W = $clog2(TELLERS_MAX + 1),
  localparam int NUM_W = $clog2(SERVICE_T * (DEPTH + TELLERS_MAX - 1) + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc_pulse,
  input  logic             dec_pulse,
  input  logic [TC_W-1:0]  tcount,
  output logic [PC_W-1:0]  pcount,
  output logic             full,
  output logic             empty,
  output logic [NUM_W-1:0] wtime,
  output logic             busy,
  output logic             no_teller
`ifdef SBQM_ERR_FLAGS_EN
  ,
  output logic             err_ovf,
  output logic             err_udf
`endif
);
  qc_state_t        state, state_nx;
  logic             inc_r, dec_r, first, changed, snap, start, load, div_done, unused_div_busy;
  logic [PC_W-1:0]  pc_snap;
  logic [TC_W-1:0]  tc_snap;
  logic [NUM_W-1:0] num, quot;
  assign full    = pcount == PC_W'(DEPTH);
  assign empty   = pcount == '0;
  assign changed = pcount != pc_snap || tcount != tc_snap;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inc_r  <= 1'b0;
      dec_r  <= 1'b0;
      pcount <= '0;
    end else begin
      inc_r  <= inc_pulse;
      dec_r  <= dec_pulse;
      pcount <= (inc_r && !dec_r && !full) ? pcount + PC_W'(1) :
                (dec_r && !inc_r && !empty) ? pcount - PC_W'(1) : pcount;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = (state == IDLE) ? (changed ? CALC : IDLE) : (load ? IDLE : CALC);
  end
  // A change seen in CALC re-snapshots immediately and suppresses the pending load
  always_comb begin
    snap  = changed;
    start = state == CALC && first && !changed && tc_snap != '0;
    load  = state == CALC && !changed && (tc_snap == '0 ? first : div_done);
    num   = NUM_W'(SERVICE_T) * (NUM_W'(pc_snap) + NUM_W'(tc_snap) - NUM_W'(1));
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_snap   <= '0;
      tc_snap   <= '0;
      first     <= 1'b0;
      busy      <= 1'b0;
      wtime     <= '0;
      no_teller <= 1'b0;
    end else begin
      first <= snap;
      if (snap) begin
        pc_snap <= pcount;
        tc_snap <= tcount;
        busy    <= 1'b1;
      end
      if (load) begin
        wtime     <= pc_snap == '0 ? '0 : tc_snap == '0 ? '1 : quot;
        no_teller <= tc_snap == '0;
        busy      <= 1'b0;
      end
    end
  end
  sbqm_div #(.W(NUM_W)) u_div (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .num    (num),
    .den    (NUM_W'(tc_snap)),
    .busy   (unused_div_busy),
    .done   (div_done),
    .quot   (quot)
  );
`ifdef SBQM_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (inc_r && !dec_r && full) err_ovf <= 1'b1;
      if (dec_r && !inc_r && empty) err_udf <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_sbqm_queue_ctrl.sv
// tb_sbqm_queue_ctrl: scoreboard bench; expected wait-time loads are queued at stimulus time
// and checked by a monitor whenever busy falls.
module tb_sbqm_queue_ctrl;
  logic       clk = 1'b0, reset_n = 1'b0, inc_pulse = 1'b0, dec_pulse = 1'b0;
  logic [1:0] tcount = 2'd0;
  logic [2:0] pcount;
  logic [4:0] wtime;
  logic       full, empty, busy, no_teller;
`ifdef SBQM_ERR_FLAGS_EN
  logic       err_ovf, err_udf;
`endif
  typedef struct {int wt; bit nt; int at;} exp_t;
  exp_t q[$];
  int   tests = 0, fails = 0, cyc = 0;
  logic busy_d = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sbqm_queue_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse),
    .tcount   (tcount),
    .pcount   (pcount),
    .full     (full),
    .empty    (empty),
    .wtime    (wtime),
    .busy     (busy),
    .no_teller(no_teller)
`ifdef SBQM_ERR_FLAGS_EN
    ,
    .err_ovf  (err_ovf),
    .err_udf  (err_udf)
`endif
  );

  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (busy_d && !busy) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_load: wtime=%0d no_teller=%0d with nothing expected", wtime, no_teller);
      end else begin
        e = q.pop_front();
        check("wtime", wtime, e.wt);
        check("no_teller", no_teller, e.nt);
        if (e.at >= 0) check("load_edge", cyc, e.at);
      end
    end
    busy_d = busy;
  end

  task automatic push(int wt, bit nt, int at);
    exp_t e;
    e = '{wt, nt, at};
    q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || q.size() != 0) && n < 60);
    if (busy || q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy=%0d pending=%0d after %0d cycles", busy, q.size(), n);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse(bit i, bit d, int wt, bit nt, bit chk);
    @(negedge clk);
    inc_pulse = i;
    dec_pulse = d;
    if (wt >= 0) push(wt, nt, chk ? cyc + 8 : -1);
    @(negedge clk);
    inc_pulse = 1'b0;
    dec_pulse = 1'b0;
    wait_idle();
  endtask

  task automatic set_t(int v, int wt, bit nt, int lat);
    @(negedge clk);
    tcount = 2'(v);
    push(wt, nt, cyc + lat);
    wait_idle();
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    check("rst_pcount", pcount, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_wtime", wtime, 0);
    check("rst_busy", busy, 0);
    check("rst_no_teller", no_teller, 0);
`ifdef SBQM_ERR_FLAGS_EN
    check("rst_err_ovf", err_ovf, 0);
    check("rst_err_udf", err_udf, 0);
`endif
    reset_n = 1'b1;
    set_t(2, 0, 0, 6);
    pulse(1, 0, 3, 0, 1);
    pulse(1, 0, 4, 0, 1);
    pulse(1, 0, 6, 0, 1);
    check("pcount_3", pcount, 3);
    set_t(1, 9, 0, 6);
    pulse(1, 0, 12, 0, 1);
    pulse(1, 0, 15, 0, 1);
    pulse(1, 0, 18, 0, 1);
    pulse(1, 0, 21, 0, 1);
    pulse(1, 0, -1, 0, 0);
    check("sat_pcount", pcount, 7);
    check("sat_full", full, 1);
    check("sat_empty", empty, 0);
    check("sat_wtime", wtime, 21);
`ifdef SBQM_ERR_FLAGS_EN
    check("err_ovf", err_ovf, 1);
`endif
    set_t(3, 9, 0, 6);
    pulse(0, 1, 8, 0, 1);
    pulse(0, 1, 7, 0, 1);
    pulse(0, 1, 6, 0, 1);
    pulse(1, 1, -1, 0, 0);
    repeat (5) @(negedge clk);
    check("both_pcount", pcount, 4);
    check("both_busy", busy, 0);
    pulse(0, 1, 5, 0, 1);
    pulse(0, 1, 4, 0, 1);
    pulse(0, 1, 3, 0, 1);
    pulse(0, 1, 0, 0, 1);
    pulse(0, 1, -1, 0, 0);
    pulse(1, 1, -1, 0, 0);
    check("udf_pcount", pcount, 0);
    check("udf_empty", empty, 1);
    check("udf_wtime", wtime, 0);
`ifdef SBQM_ERR_FLAGS_EN
    check("err_udf", err_udf, 1);
`endif
    pulse(1, 0, 3, 0, 1);
    pulse(1, 0, 4, 0, 1);
    set_t(0, 31, 1, 2);
    check("nt_pcount", pcount, 2);
    set_t(1, 6, 0, 6);
    @(negedge clk);
    inc_pulse = 1'b1;
    c = cyc;
    push(12, 0, c + 11);
    @(negedge clk);
    inc_pulse = 1'b0;
    repeat (2) @(negedge clk);
    inc_pulse = 1'b1;
    @(negedge clk);
    inc_pulse = 1'b0;
    wait_idle();
    check("restart_pcount", pcount, 4);
    check("restart_wtime", wtime, 12);
    check("pending", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule

// File: doc/sbqm_queue_ctrl.md
Name: sbqm_queue_ctrl

Overview:
- Downstream consumer of the entry and exit photocell pulse stages. Each of those stages delivers exactly one single-cycle count pulse per customer crossing.
- Keeps the people-in-queue count (pcount) and the full and empty flags.
- Computes the estimated wait time with a multi-cycle sequential divider: wtime = SERVICE_T*(pcount+tcount-1)/tcount, forced to 0 when the queue is empty.
- Outputs drive the bank display driver.

Parameters:
- DEPTH, 7: maximum queue occupancy; pcount saturates here.
- TELLERS_MAX, 3: maximum number of active tellers.
- SERVICE_T, 3: minutes of service per customer.
- Derived localparams (not overridable):
  - PC_W = $clog2(DEPTH+1)
  - TC_W = $clog2(TELLERS_MAX+1)
  - NUM_W = $clog2(SERVICE_T*(DEPTH+TELLERS_MAX-1)+1)
  - wtime width = NUM_W

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- inc_pulse  in  1  single-cycle pulse from the entry-side pulse stage.
- dec_pulse  in  1  single-cycle pulse from the exit-side pulse stage.
- tcount  in  TC_W  number of active tellers, quasi-static, 0..TELLERS_MAX.
- pcount  out  PC_W  registered queue occupancy.
- full  out  1  pcount==DEPTH.
- empty  out  1  pcount==0.
- wtime  out  NUM_W  registered estimated wait in minutes.
- busy  out  1  high while a wait-time calculation is in flight.
- no_teller  out  1  registered; high while tcount==0.

Behaviour:
- Reset values (asynchronous, active-low): pcount=0, empty=1, full=0, wtime=0, busy=0, no_teller=0, FSM in IDLE, operand snapshots 0.
- Count update (registered, one edge after the pulse is sampled):
  - inc only and not full: pcount+1.
  - dec only and not empty: pcount-1.
  - inc and dec in the same cycle: pcount unchanged. This holds even when full or empty.
  - inc while full: ignored, no wrap.
  - dec while empty: ignored, no wrap.
- full and empty are decoded from the registered pcount, so they change in the same cycle as pcount.
- Wait-time FSM states: IDLE, CALC.
- IDLE:
  - If pcount != pc_snap or tcount != tc_snap: snapshot both, set busy=1, go to CALC.
  - The numerator SERVICE_T*(pc_snap+tc_snap-1) is computed at NUM_W width; SERVICE_T is a constant multiply.
- CALC:
  - Restoring shift-subtract division, one quotient bit per cycle, NUM_W iterations.
  - On the final iteration edge, load wtime and clear busy, then return to IDLE.
  - Latency: a pulse sampled at edge N updates pcount at N+1, the FSM enters CALC at N+2, and wtime is loaded at N+1+NUM_W+1. With defaults (NUM_W=5) that is edge N+7.
- Restart: if pcount or tcount changes while in CALC, abort, re-snapshot on the next edge and restart. wtime holds its old value until a calculation completes.
- Special cases at load time:
  - pc_snap==0: wtime=0 regardless of tcount.
  - tc_snap==0 and pc_snap>0: wtime=all ones, no_teller=1. No division is performed; the load happens one edge after entering CALC.
- no_teller follows tcount==0 at every load and is cleared by any load with tc_snap>0.
- Reset mid-CALC: returns immediately to reset values. The next calculation starts only on a later pcount or tcount change relative to the zeroed snapshots.
- Pulses are never lost during CALC; counting is independent of the FSM.

Optional Feature:
- Macro: SBQM_ERR_FLAGS_EN.
- Defined:
  - Adds outputs err_ovf and err_udf, 1 bit each, reset 0.
  - err_ovf sets sticky on inc-only while full.
  - err_udf sets sticky on dec-only while empty.
  - Both clear only on reset.
- Undefined: the ports are absent. Overflow and underflow are silently ignored as above.

Decomposition:
- Package sbqm_pkg holds:
  - typedef enum logic [0:0] {IDLE, CALC} qc_state_t
  - default constants SBQM_DEPTH=7, SBQM_TELLERS_MAX=3, SBQM_SERVICE_T=3
- One sub-module, sbqm_div:
  - Sequential unsigned restoring divider, parameter W.
  - Ports: clk, reset_n, start, num, den, busy, done (1-cycle), quot.
  - Instantiated by the CALC state.

Test Plan:
- Reset -> pcount=0, empty=1, full=0, wtime=0, busy=0, no_teller=0.
- tcount=2, three inc pulses spaced 10 cycles apart -> pcount=3 and wtime=6. The last wtime load lands 7 edges after the final pulse is sampled.
- tcount=1, eight inc pulses -> pcount saturates at 7, full=1, wtime=21; with SBQM_ERR_FLAGS_EN, err_ovf=1. Then change tcount to 3 -> wtime=9.
- pcount=4, simultaneous inc and dec -> pcount stays 4, no recalculation. Then single dec pulses down to 0 plus one extra dec -> empty=1, wtime=0, pcount stays 0; with SBQM_ERR_FLAGS_EN, err_udf=1.
- pcount=2, tcount=0 -> wtime=31, no_teller=1. Then tcount=1 -> wtime=6, no_teller=0.
- inc pulse arriving 2 cycles into a CALC -> abort and restart. The final wtime matches the new pcount, with no intermediate stale load.
